sgpio_led_chain: RTL and testbench
==================================

# sgpio_led_chain

Parametrised successor to the single-chip 74LV164D LED driver. Serialises an N-bit LED word onto a chain of one or more 74LV164D shift registers (DSA/DSB, CP, MR_N). Adds a programmable serial-clock divider, selectable bit order, latest-wins request buffering, change suppression, optional periodic refresh and an enable-driven chain clear. Sits between the status/debug logic and the board SGPIO debug pins in the 20 MHz `aclk` domain.

## Interface
- `P_NUMBER_LEDS`, 8: LED word width. Equals 8 × chained chips; range 1..256.
- `P_HALF_DIV`, 100: aclk cycles per CP half-period. 100 gives a 100 kHz CP at 20 MHz; minimum 1.
- `P_MR_CYCLES`, 20: aclk cycles MR_N is held low after reset release or enable rise; minimum 1.
- `P_MSB_FIRST`, 1: 1 = `i_data[N-1]` shifted first; 0 = `i_data[0]` shifted first.
- `P_REFRESH_CYCLES`, 0: idle aclk cycles before a forced re-send of the current word; 0 disables refresh.

Ports:
- `aclk`  in  1  logic clock, 20 MHz.
- `areset`  in  1  asynchronous reset, active-high.
- `en`  in  1  asynchronous enable, active-high; synchronised internally with 2 flops.
- `i_data`  in  N  LED word; sampled only when `i_valid`=1.
- `i_valid`  in  1  data strobe, any cycle; no backpressure.
- `SGPIO_FPGA_DBG_CPU0_DATA`  out  1  serial data to DSA/DSB.
- `SGPIO_FPGA_DBG_RST_N`  out  1  MR_N, active-low chain clear.
- `SGPIO_FPGA_DBG_CLK_100k`  out  1  CP, shift clock.
- `o_busy`  out  1  high in every state except IDLE.
- `o_frame_done`  out  1  one-cycle pulse when a frame completes.

## Operation
- Registers: `r_req` (latest accepted word), `r_shown` (word currently latched in the chain), shift register, bit counter (log2 N+1), divider counter, refresh counter. All outputs are registered.
- Accept: `i_valid`=1 loads `r_req <= i_data` in any state, including mid-frame and during MR.
- Change suppression: a frame starts only from IDLE, when `r_req != r_shown` or the refresh timer expires.
- States:
  - CLEAR: MR_N=0 for P_MR_CYCLES cycles. `r_shown <= 0`. Then IDLE.
  - IDLE: CP=0, DATA=0, MR_N=1.
  - LOW: DATA = current bit, CP=0, for P_HALF_DIV cycles. Then HIGH.
  - HIGH: CP=1, DATA held, for P_HALF_DIV cycles. After the last bit, go to IDLE; otherwise go to LOW with the next bit.
  - DISABLED: MR_N=0, CP=0, DATA=0.
- Frame start: the shift register snapshots `r_req`. A later `r_req` change does not alter the frame in flight.
- Frame end: `r_shown <= snapshot` and `o_frame_done`=1 for one cycle. IDLE then re-evaluates immediately, so a word received mid-frame is sent back-to-back.
- Refresh: the counter runs only in IDLE and clears on any frame start. At P_REFRESH_CYCLES it starts a frame even when `r_req == r_shown`.
- Enable: synchronised `en`=0 goes to DISABLED from any state, aborting any frame; `r_req` is retained. An `en` rising edge goes to CLEAR, after which `r_req` (if nonzero) is re-sent via change detection.
- Reset values: state=CLEAR (counter restarts at release), MR_N=0, CP=0, DATA=0, `o_busy`=1, `o_frame_done`=0, `r_req`=0, `r_shown`=0. With synchronised `en`=0 at release, the block enters DISABLED instead of CLEAR.

## Timing
- Latency: `i_valid` at cycle t in IDLE with a changed word → `r_req` updated at t+1 → LOW entered, DATA = first bit and `o_busy`=1 at t+2.
- First CP rising edge at t+2+P_HALF_DIV. DATA is stable P_HALF_DIV cycles before and after every CP rise.
- Frame length: 2·P_HALF_DIV·N cycles from LOW entry to IDLE entry. `o_frame_done` is asserted in the first IDLE cycle.
- Repeat strobes with an identical word: no CP activity.
- Several strobes during one frame: only the last value is sent next.
- Simultaneous `i_valid` and frame end: the new value is compared in the following IDLE cycle.
- `en` path: 2 aclk synchroniser latency, then DISABLED or CLEAR on the next edge.
- `areset` mid-frame: outputs take reset values immediately (asynchronously); the frame is lost.

## Test plan
- N=8, H=2, MSB-first, en=1. After CLEAR, `i_valid` with 0xA5 → `o_busy` rises 2 cycles later; bits 1,0,1,0,0,1,0,1 on DATA across 8 CP rises; frame of 32 cycles; `o_frame_done` pulses once.
- 0xA5 sent, then `i_valid` with 0xA5 three more times → no CP edges, `o_busy` stays 0.
- During a 0x0F frame, strobe 0x11 then 0x22 → 0x0F completes intact, then 0x22 is sent back-to-back and 0x11 never appears; `r_shown`=0x22.
- P_MSB_FIRST=0, N=16, 0x8001 → DATA order 1, then 14 zeros, then 1; 16 CP rises.
- P_REFRESH_CYCLES=50, 0x3C shown, no strobes → identical 0x3C frame starts 50 idle cycles after each frame end.
- `en` dropped mid-frame → MR_N=0 and CP=0 within 3 cycles. On `en` rise, MR_N low for P_MR_CYCLES, then 0x3C re-sent. `areset` mid-frame → all outputs at reset values immediately.

Source files
------------

// File: rtl/sgpio_led_chain_if.sv
// Request bus between the status/debug logic and the SGPIO LED chain driver.
// The producer drives the word and strobe; the driver reports activity back.
interface sgpio_led_chain_if #(
    parameter int unsigned P_NUMBER_LEDS = 8
);
    logic [P_NUMBER_LEDS-1:0] i_data;
    logic                     i_valid;
    logic                     o_busy;
    logic                     o_frame_done;

    modport master (
        output i_data,
        output i_valid,
        input  o_busy,
        input  o_frame_done
    );

    modport slave (
        input  i_data,
        input  i_valid,
        output o_busy,
        output o_frame_done
    );
endinterface

// File: rtl/sgpio_led_chain.sv
// Serialises an LED word onto a chain of 74LV164D shift registers (DSA/DSB, CP, MR_N),
// with CP divider, bit-order select, latest-wins buffering, change suppression and refresh.
module sgpio_led_chain #(
    parameter int unsigned P_NUMBER_LEDS    = 8,
    parameter int unsigned P_HALF_DIV       = 100,
    parameter int unsigned P_MR_CYCLES      = 20,
    parameter int unsigned P_MSB_FIRST      = 1,
    parameter int unsigned P_REFRESH_CYCLES = 0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  en,
    sgpio_led_chain_if.slave      bus,
    output logic                  SGPIO_FPGA_DBG_CPU0_DATA,
    output logic                  SGPIO_FPGA_DBG_RST_N,
    output logic                  SGPIO_FPGA_DBG_CLK_100k
);
    localparam int unsigned CntMax = (P_HALF_DIV > P_MR_CYCLES) ? P_HALF_DIV : P_MR_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam int unsigned BitW   = $clog2(P_NUMBER_LEDS + 1);
    localparam int unsigned RefW   = $clog2(P_REFRESH_CYCLES + 2);

    localparam logic [CntW-1:0] HalfLast = CntW'(P_HALF_DIV - 1);
    localparam logic [CntW-1:0] MrLast   = CntW'(P_MR_CYCLES - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(P_NUMBER_LEDS - 1);
    localparam logic [RefW-1:0] RefLast  = RefW'(P_REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {StClear, StIdle, StLow, StHigh, StDisabled} state_e;

    state_e                   state_q, state_d;
    logic                     en_meta_q, en_sync_q;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [BitW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [RefW-1:0]          ref_cnt_q, ref_cnt_d;
    logic [P_NUMBER_LEDS-1:0] shift_q, shift_d;
    logic [P_NUMBER_LEDS-1:0] snap_q, r_req_q, r_shown_q;
    logic                     data_q, data_d, cp_q, cp_d, mr_n_q, mr_n_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     half_done, ref_hit, frame_start, frame_end, cur_bit;

    assign half_done   = (cnt_q == HalfLast);
    assign ref_hit     = (P_REFRESH_CYCLES != 0) && (ref_cnt_q == RefLast);
    assign frame_start = (state_q == StIdle) && (state_d == StLow);
    assign frame_end   = (state_q == StHigh) && (state_d == StIdle);

    // Synchroniser resets high so a board with en tied high clears the chain from release.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            en_meta_q <= 1'b1;
            en_sync_q <= 1'b1;
        end else begin
            en_meta_q <= en;
            en_sync_q <= en_meta_q;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) state_q <= StClear;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!en_sync_q) begin
            state_d = StDisabled;
        end else begin
            case (state_q)
                StDisabled: state_d = StClear;
                StClear:    if (cnt_q == MrLast) state_d = StIdle;
                StIdle:     if ((r_req_q != r_shown_q) || ref_hit) state_d = StLow;
                StLow:      if (half_done) state_d = StHigh;
                StHigh: begin
                    if (half_done) state_d = (bit_cnt_q == BitLast) ? StIdle : StLow;
                end
                default:    state_d = StClear;
            endcase
        end
    end

    always_comb begin
        cnt_d = '0;
        if ((state_d == state_q) && (state_q inside {StClear, StLow, StHigh})) begin
            cnt_d = cnt_q + 1'b1;
        end
        ref_cnt_d = '0;
        if ((P_REFRESH_CYCLES != 0) && (state_q == StIdle) && (state_d == StIdle)) begin
            ref_cnt_d = ref_cnt_q + 1'b1;
        end
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (frame_start) begin
            bit_cnt_d = '0;
            shift_d   = r_req_q;
        end else if ((state_q == StHigh) && (state_d == StLow)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = (P_MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
        end
        cur_bit = (P_MSB_FIRST != 0) ? shift_d[P_NUMBER_LEDS-1] : shift_d[0];
    end

    // Outputs are decoded from the next state so the pins come straight from flops.
    always_comb begin
        data_d = (state_d inside {StLow, StHigh}) && cur_bit;
        cp_d   = (state_d == StHigh);
        mr_n_d = !(state_d inside {StClear, StDisabled});
        busy_d = (state_d != StIdle);
        done_d = frame_end;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            ref_cnt_q <= '0;
            shift_q   <= '0;
            snap_q    <= '0;
            r_req_q   <= '0;
            r_shown_q <= '0;
            data_q    <= 1'b0;
            cp_q      <= 1'b0;
            mr_n_q    <= 1'b0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            ref_cnt_q <= ref_cnt_d;
            shift_q   <= shift_d;
            if (frame_start) snap_q <= r_req_q;
            if (bus.i_valid) r_req_q <= bus.i_data;
            if (state_q == StClear) r_shown_q <= '0;
            else if (frame_end)     r_shown_q <= snap_q;
            data_q    <= data_d;
            cp_q      <= cp_d;
            mr_n_q    <= mr_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign SGPIO_FPGA_DBG_CPU0_DATA = data_q;
    assign SGPIO_FPGA_DBG_CLK_100k  = cp_q;
    assign SGPIO_FPGA_DBG_RST_N     = mr_n_q;
    assign bus.o_busy               = busy_q;
    assign bus.o_frame_done         = done_q;
endmodule

// File: tb/tb_sgpio_led_chain.sv
// Directed bench for sgpio_led_chain: three instances cover MSB-first, LSB-first/16-bit
// and refresh/enable configurations, all with a 2-cycle CP half-period and 4-cycle MR.
module tb_sgpio_led_chain;
    localparam int unsigned H  = 2;
    localparam int unsigned MR = 4;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic en_a = 1'b1, en_b = 1'b1, en_c = 1'b0;
    logic data_a, mr_a, cp_a, data_b, mr_b, cp_b, data_c, mr_c, cp_c;
    int   tests = 0, fails = 0;
    int   sel = 0;
    logic s_data, s_mr, s_cp, s_busy, s_done;

    logic [31:0] w_bits;
    int          w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at;

    always #5 clk = ~clk;

    sgpio_led_chain_if #(.P_NUMBER_LEDS(8))  bus_a ();
    sgpio_led_chain_if #(.P_NUMBER_LEDS(16)) bus_b ();
    sgpio_led_chain_if #(.P_NUMBER_LEDS(8))  bus_c ();

    sgpio_led_chain #(.P_NUMBER_LEDS(8), .P_HALF_DIV(H), .P_MR_CYCLES(MR), .P_MSB_FIRST(1),
                      .P_REFRESH_CYCLES(0)) dut_a (
        .aclk(clk), .areset(areset), .en(en_a), .bus(bus_a),
        .SGPIO_FPGA_DBG_CPU0_DATA(data_a), .SGPIO_FPGA_DBG_RST_N(mr_a),
        .SGPIO_FPGA_DBG_CLK_100k(cp_a));

    sgpio_led_chain #(.P_NUMBER_LEDS(16), .P_HALF_DIV(H), .P_MR_CYCLES(MR), .P_MSB_FIRST(0),
                      .P_REFRESH_CYCLES(0)) dut_b (
        .aclk(clk), .areset(areset), .en(en_b), .bus(bus_b),
        .SGPIO_FPGA_DBG_CPU0_DATA(data_b), .SGPIO_FPGA_DBG_RST_N(mr_b),
        .SGPIO_FPGA_DBG_CLK_100k(cp_b));

    sgpio_led_chain #(.P_NUMBER_LEDS(8), .P_HALF_DIV(H), .P_MR_CYCLES(MR), .P_MSB_FIRST(1),
                      .P_REFRESH_CYCLES(50)) dut_c (
        .aclk(clk), .areset(areset), .en(en_c), .bus(bus_c),
        .SGPIO_FPGA_DBG_CPU0_DATA(data_c), .SGPIO_FPGA_DBG_RST_N(mr_c),
        .SGPIO_FPGA_DBG_CLK_100k(cp_c));

    assign s_data = (sel == 0) ? data_a : (sel == 1) ? data_b : data_c;
    assign s_mr   = (sel == 0) ? mr_a   : (sel == 1) ? mr_b   : mr_c;
    assign s_cp   = (sel == 0) ? cp_a   : (sel == 1) ? cp_b   : cp_c;
    assign s_busy = (sel == 0) ? bus_a.o_busy : (sel == 1) ? bus_b.o_busy : bus_c.o_busy;
    assign s_done = (sel == 0) ? bus_a.o_frame_done :
                    (sel == 1) ? bus_b.o_frame_done : bus_c.o_frame_done;

    // Strobe one word for one cycle; returns on the negedge where i_valid drops.
    task automatic pulse(input int which, input logic [15:0] v);
        @(negedge clk);
        case (which)
            0:       begin bus_a.i_data = v[7:0]; bus_a.i_valid = 1'b1; end
            1:       begin bus_b.i_data = v;      bus_b.i_valid = 1'b1; end
            default: begin bus_c.i_data = v[7:0]; bus_c.i_valid = 1'b1; end
        endcase
        @(negedge clk);
        bus_a.i_valid = 1'b0;
        bus_b.i_valid = 1'b0;
        bus_c.i_valid = 1'b0;
    endtask

    // Observe the selected DUT for ncyc negedges; DATA is captured at each CP rise.
    task automatic watch(input int ncyc, output logic [31:0] bits, output int rises,
                         output int busy_n, output int first_busy, output int first_rise,
                         output int done_n, output int done_at);
        logic cp_prev;
        bits = '0; rises = 0; busy_n = 0; first_busy = -1; first_rise = -1;
        done_n = 0; done_at = -1;
        cp_prev = s_cp;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            if (s_busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = k;
            end
            if (s_cp && !cp_prev) begin
                rises++;
                bits = {bits[30:0], s_data};
                if (first_rise < 0) first_rise = k;
            end
            if (s_done) begin
                done_n++;
                done_at = k;
            end
            cp_prev = s_cp;
        end
    endtask

    task automatic test_reset();
        int k;
        sel = 0;
        repeat (2) @(negedge clk);
        tests++; if (s_mr !== 1'b0) begin fails++; $display("FAIL rst_mr_n: got %b want 0", s_mr); end
        tests++; if (s_cp !== 1'b0) begin fails++; $display("FAIL rst_cp: got %b want 0", s_cp); end
        tests++; if (s_data !== 1'b0) begin fails++; $display("FAIL rst_data: got %b want 0", s_data); end
        tests++; if (s_busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", s_busy); end
        tests++; if (s_done !== 1'b0) begin fails++; $display("FAIL rst_done: got %b want 0", s_done); end
        areset = 1'b0;
        k = 0;
        while (k < 50 && !(mr_a === 1'b1 && mr_b === 1'b1)) begin
            @(negedge clk);
            k++;
        end
        tests++; if (k >= 50) begin fails++; $display("FAIL rst_clear_end: got timeout want MR_N high"); end
        tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL rst_idle_busy: got %b want 0", s_busy); end
    endtask

    task automatic test_first_frame();
        sel = 0;
        pulse(0, 16'h00A5);
        tests++; if (s_busy !== 1'b0) begin fails++; $display("FAIL a5_busy_t1: got %b want 0", s_busy); end
        watch(40, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_fbusy !== 1) begin fails++; $display("FAIL a5_busy_rise: got %0d want 1", w_fbusy); end
        tests++; if (w_frise !== 3) begin fails++; $display("FAIL a5_first_cp: got %0d want 3", w_frise); end
        tests++; if (w_rises !== 8) begin fails++; $display("FAIL a5_rises: got %0d want 8", w_rises); end
        tests++; if (w_bits !== 32'hA5) begin fails++; $display("FAIL a5_bits: got %h want a5", w_bits); end
        tests++; if (w_busy !== 32) begin fails++; $display("FAIL a5_len: got %0d want 32", w_busy); end
        tests++; if (w_done !== 1) begin fails++; $display("FAIL a5_done_n: got %0d want 1", w_done); end
        tests++; if (w_done_at !== 33) begin fails++; $display("FAIL a5_done_at: got %0d want 33", w_done_at); end
    endtask

    task automatic test_repeat_suppress();
        sel = 0;
        fork
            begin
                pulse(0, 16'h00A5);
                pulse(0, 16'h00A5);
                pulse(0, 16'h00A5);
            end
            watch(12, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        join
        tests++; if (w_rises !== 0) begin fails++; $display("FAIL rep_rises: got %0d want 0", w_rises); end
        tests++; if (w_busy !== 0) begin fails++; $display("FAIL rep_busy: got %0d want 0", w_busy); end
        tests++; if (w_done !== 0) begin fails++; $display("FAIL rep_done: got %0d want 0", w_done); end
    endtask

    task automatic test_latest_wins();
        sel = 0;
        pulse(0, 16'h000F);
        fork
            watch(90, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
            begin
                repeat (5) @(negedge clk);
                pulse(0, 16'h0011);
                repeat (3) @(negedge clk);
                pulse(0, 16'h0022);
            end
        join
        tests++; if (w_rises !== 16) begin fails++; $display("FAIL lw_rises: got %0d want 16", w_rises); end
        tests++; if (w_bits !== 32'h0F22) begin fails++; $display("FAIL lw_bits: got %h want 0f22", w_bits); end
        tests++; if (w_busy !== 64) begin fails++; $display("FAIL lw_len: got %0d want 64", w_busy); end
        tests++; if (w_done !== 2) begin fails++; $display("FAIL lw_done_n: got %0d want 2", w_done); end
        tests++; if (w_done_at !== 66) begin fails++; $display("FAIL lw_b2b: got %0d want 66", w_done_at); end
        pulse(0, 16'h0022);
        watch(20, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_rises !== 0) begin fails++; $display("FAIL lw_shown22: got %0d want 0", w_rises); end
    endtask

    task automatic test_lsb_first();
        sel = 1;
        pulse(1, 16'h8001);
        watch(70, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_rises !== 16) begin fails++; $display("FAIL lsb_rises: got %0d want 16", w_rises); end
        tests++; if (w_bits !== 32'h8001) begin fails++; $display("FAIL lsb_8001: got %h want 8001", w_bits); end
        tests++; if (w_busy !== 64) begin fails++; $display("FAIL lsb_len: got %0d want 64", w_busy); end
        tests++; if (w_done !== 1) begin fails++; $display("FAIL lsb_done_n: got %0d want 1", w_done); end
        pulse(1, 16'h0003);
        watch(70, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_bits !== 32'hC000) begin fails++; $display("FAIL lsb_0003: got %h want c000", w_bits); end
    endtask

    task automatic test_refresh();
        int k;
        sel = 2;
        @(negedge clk);
        en_c = 1'b1;
        k = 0;
        while (k < 20 && s_mr !== 1'b1) begin
            @(negedge clk);
            k++;
        end
        tests++; if (k >= 20) begin fails++; $display("FAIL ref_clear: got timeout want MR_N high"); end
        pulse(2, 16'h003C);
        watch(140, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_fbusy !== 1) begin fails++; $display("FAIL ref_start: got %0d want 1", w_fbusy); end
        tests++; if (w_rises !== 16) begin fails++; $display("FAIL ref_rises: got %0d want 16", w_rises); end
        tests++; if (w_bits !== 32'h3C3C) begin fails++; $display("FAIL ref_bits: got %h want 3c3c", w_bits); end
        tests++; if (w_busy !== 64) begin fails++; $display("FAIL ref_len: got %0d want 64", w_busy); end
        tests++; if (w_done_at !== 115) begin fails++; $display("FAIL ref_period: got %0d want 115", w_done_at); end
    endtask

    task automatic test_enable();
        int k;
        int first_hi;
        sel = 2;
        pulse(2, 16'h005A);
        repeat (6) @(negedge clk);
        en_c = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (s_mr !== 1'b0) begin fails++; $display("FAIL dis_mr_n: got %b want 0", s_mr); end
        tests++; if (s_cp !== 1'b0) begin fails++; $display("FAIL dis_cp: got %b want 0", s_cp); end
        tests++; if (s_data !== 1'b0) begin fails++; $display("FAIL dis_data: got %b want 0", s_data); end
        tests++; if (s_busy !== 1'b1) begin fails++; $display("FAIL dis_busy: got %b want 1", s_busy); end
        watch(5, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_rises !== 0) begin fails++; $display("FAIL dis_quiet: got %0d want 0", w_rises); end
        en_c = 1'b1;
        first_hi = -1;
        k = 0;
        while (k < 20 && first_hi < 0) begin
            @(negedge clk);
            k++;
            if (s_mr === 1'b1) first_hi = k;
        end
        tests++; if (first_hi !== 3 + MR) begin fails++; $display("FAIL en_mr_len: got %0d want %0d", first_hi, 3 + MR); end
        watch(40, w_bits, w_rises, w_busy, w_fbusy, w_frise, w_done, w_done_at);
        tests++; if (w_fbusy !== 1) begin fails++; $display("FAIL en_resend_start: got %0d want 1", w_fbusy); end
        tests++; if (w_bits !== 32'h5A) begin fails++; $display("FAIL en_resend_bits: got %h want 5a", w_bits); end
        tests++; if (w_done_at !== 33) begin fails++; $display("FAIL en_resend_done: got %0d want 33", w_done_at); end
    endtask

    task automatic test_areset_async();
        sel = 0;
        pulse(0, 16'h00FF);
        repeat (3) @(negedge clk);
        tests++; if (s_cp !== 1'b1) begin fails++; $display("FAIL ar_pre_cp: got %b want 1", s_cp); end
        #2 areset = 1'b1;
        #1;
        tests++; if (s_mr !== 1'b0) begin fails++; $display("FAIL ar_mr_n: got %b want 0", s_mr); end
        tests++; if (s_cp !== 1'b0) begin fails++; $display("FAIL ar_cp: got %b want 0", s_cp); end
        tests++; if (s_data !== 1'b0) begin fails++; $display("FAIL ar_data: got %b want 0", s_data); end
        tests++; if (s_busy !== 1'b1) begin fails++; $display("FAIL ar_busy: got %b want 1", s_busy); end
        tests++; if (s_done !== 1'b0) begin fails++; $display("FAIL ar_done: got %b want 0", s_done); end
        @(negedge clk);
        areset = 1'b0;
    endtask

    initial begin
        bus_a.i_data = '0; bus_a.i_valid = 1'b0;
        bus_b.i_data = '0; bus_b.i_valid = 1'b0;
        bus_c.i_data = '0; bus_c.i_valid = 1'b0;
        test_reset();
        test_first_frame();
        test_repeat_suppress();
        test_latest_wins();
        test_lsb_first();
        test_refresh();
        test_enable();
        test_areset_async();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
